mmu_encoder: RTL and testbench
==============================

# mmu_encoder

Issue-side counterpart of the MMU instruction decoder. Accepts load/store requests from the control path over a valid/ready handshake and packs them into the 30-bit MMU instruction word that the decoder consumes. Expands a burst request into consecutive single-word instructions with an incrementing memory location. Buffers the packed words in a small FIFO ahead of the MMU.

## Interface
Parameters:
- DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_ld  in  1  load request.
- req_st  in  1  store request.
- req_reg_addr  in  4  register address.
- req_mem_addr  in  4  first memory location address.
- req_sl_select  in  4  store/load select.
- req_len  in  4  number of words minus 1 (0 gives 1 word, 15 gives 16 words).
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  consumer takes the head word.
- instruction  out  30  packed MMU instruction.
- err_invalid  out  1  one-cycle pulse when a request is rejected.
- busy  out  1  high while the burst is active or the FIFO is non-empty.

## Operation
- Field group F = {st, ld, reg_addr[3:0], mem_loca_addr[3:0], sl_select[3:0]}, 14 bits.
- Word packing:
  - instruction[29:16] = {st, ld, reg, mem, sel}.
  - instruction[13:0] = {sel, mem, reg, ld, st}, which is the mirrored order of the same fields.
  - instruction[15:14] are as described under Configuration.
- The FSM has two states, IDLE and BURST. Reset state is IDLE.
- req_ready = (state == IDLE).
- A handshake in IDLE where exactly one of req_ld or req_st is high:
  - latches the fields and req_len into a remaining-word counter;
  - moves the FSM to BURST.
- A handshake in IDLE where req_ld == req_st (both high or both low):
  - the request is consumed and nothing is enqueued;
  - err_invalid pulses high for the next cycle;
  - the FSM stays in IDLE.
- In BURST, each cycle with the FIFO not full:
  - one word is pushed using the current mem address;
  - mem increments by 1 modulo 16, so 15 wraps to 0;
  - the counter decrements.
- When the word pushed has counter == 0, the FSM returns to IDLE.
- A full FIFO stalls BURST, and no field changes while stalled.
- The full flag is evaluated before any same-cycle pop. A push and a pop in the same cycle are allowed only when the FIFO is not full.
- A pop happens when instr_valid && instr_ready. There is no write-to-read bypass.
- Reset mid-burst: the counter is cleared, the FIFO is flushed and the FSM enters IDLE. Partially issued bursts are not resumed.

## Timing
Reset values:
- req_ready = 1
- instr_valid = 0
- instruction = 0
- err_invalid = 0
- busy = 0

Latency:
- A request accepted at edge N pushes its first word at edge N+1.
- instr_valid is high from cycle N+2 (registered FIFO output).
- Burst throughput is one word per cycle when instr_ready is held high.
- req_ready returns high the cycle after the last push.

Handshake rules:
- instruction is stable while instr_valid is high and instr_ready is low.
- The bench drives request inputs stable while req_valid is high.
- req_valid must not depend on req_ready.

## Configuration
- MMU_ENCODER_PARITY_EN defined:
  - instruction[15] = even parity (XOR) of instruction[29:16];
  - instruction[14] = XOR of instruction[13:0].
- MMU_ENCODER_PARITY_EN undefined: instruction[15:14] = 2'b00.

## Structure
- Package mmu_pkg holds:
  - field widths REG_W = 4, MEM_W = 4, SEL_W = 4;
  - INSTR_W = 30 and the half offsets HI_LSB = 16, LO_MSB = 13;
  - the FSM state enum {IDLE, BURST}.
- The decoder shares the same package.
- Sub-module mmu_instr_fifo is a synchronous FIFO parameterized by DEPTH and width, with full/empty flags and a registered head.
- Packing logic stays inline in mmu_encoder.

## Test plan
1. Single load:
   - stimulus: ld=1, reg=3, mem=5, sel=9, len=0, instr_ready=1;
   - response: one word with [29:16]=14'b01_0011_0101_1001 and [13:0]=14'b1001_0101_0011_10; valid first seen 2 cycles after accept.
2. Burst wrap:
   - stimulus: st=1, mem=14, len=3, instr_ready=1;
   - response: four words with mem 14, 15, 0, 1 on consecutive cycles; req_ready low for 4 cycles.
3. Backpressure:
   - stimulus: DEPTH=4, len=7, instr_ready=0;
   - response: exactly 4 words are buffered and the FSM stays in BURST; releasing instr_ready drains all 8 words in order with none lost or duplicated.
4. Invalid opcodes:
   - stimulus: ld=st=1, then ld=st=0;
   - response: each request is consumed with a one-cycle err_invalid pulse; instr_valid stays 0.
5. Reset mid-burst:
   - stimulus: assert rst_n=0 asynchronously after 2 words of a len=5 burst;
   - response: outputs go to their reset values immediately; after release the FIFO is empty and req_ready=1.
6. Parity, run with and without MMU_ENCODER_PARITY_EN:
   - stimulus: the scenario 1 request;
   - response: [15:14]=2'b00 when the macro is off; when it is on, [15]=XOR([29:16]) and [14]=XOR([13:0]).

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU instruction encoder and decoder:
// field widths, instruction word layout and FSM state encoding.
package mmu_pkg;

  localparam int REG_W   = 4;
  localparam int MEM_W   = 4;
  localparam int SEL_W   = 4;
  localparam int FIELD_W = 2 + REG_W + MEM_W + SEL_W;
  localparam int INSTR_W = 30;
  localparam int HI_LSB  = 16;
  localparam int LO_MSB  = 13;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/mmu_instr_fifo.sv
// Synchronous FIFO with a registered head stage; o_full counts the head
// entry too, so total occupancy never exceeds DEPTH.
module mmu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ready,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic [CW-1:0]    w_mem_count;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_push      = i_push && !o_full;
  assign w_pop       = r_valid && i_ready;
  assign w_mem_count = r_count - CW'(r_valid);
  // Head refills only from words already stored, so a push is never visible the same cycle.
  assign w_load      = (w_mem_count != '0) && (!r_valid || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_valid  <= 1'b1;
        r_head   <= r_mem[r_rd_ptr];
      end else if (w_pop) begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_rdata = r_head;

endmodule

// File: rtl/mmu_encoder.sv
// Packs load/store requests into 30-bit MMU instruction words, expanding bursts.
// Define MMU_ENCODER_PARITY_EN to fill instruction[15:14] with half-word parity.
module mmu_encoder
  import mmu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_ld,
  input  logic               req_st,
  input  logic [REG_W-1:0]   req_reg_addr,
  input  logic [MEM_W-1:0]   req_mem_addr,
  input  logic [SEL_W-1:0]   req_sl_select,
  input  logic [3:0]         req_len,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic               err_invalid,
  output logic               busy
);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_ld;
  logic               r_st;
  logic [REG_W-1:0]   r_reg;
  logic [MEM_W-1:0]   r_mem;
  logic [SEL_W-1:0]   r_sel;
  logic [3:0]         r_cnt;
  logic               r_err;

  logic               w_accept;
  logic               w_op_ok;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [FIELD_W-1:0] w_hi;
  logic [FIELD_W-1:0] w_lo;
  logic [1:0]         w_par;
  logic [INSTR_W-1:0] w_word;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_op_ok  = req_ld ^ req_st;
  assign w_push   = (r_state == BURST) && !w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_op_ok)    w_state_next = BURST;
      BURST:   if (w_push && r_cnt == 4'd0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld  <= 1'b0;
      r_st  <= 1'b0;
      r_reg <= '0;
      r_mem <= '0;
      r_sel <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_op_ok;
      if (w_accept && w_op_ok) begin
        r_ld  <= req_ld;
        r_st  <= req_st;
        r_reg <= req_reg_addr;
        r_mem <= req_mem_addr;
        r_sel <= req_sl_select;
        r_cnt <= req_len;
      end else if (w_push) begin
        r_mem <= r_mem + MEM_W'(1);
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Low half carries the same fields as the high half in mirrored order.
  assign w_hi = {r_st, r_ld, r_reg, r_mem, r_sel};
  assign w_lo = {r_sel, r_mem, r_reg, r_ld, r_st};
`ifdef MMU_ENCODER_PARITY_EN
  assign w_par = {^w_hi, ^w_lo};
`else
  assign w_par = 2'b00;
`endif
  assign w_word = {w_hi, w_par, w_lo};

  mmu_instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_ready (instr_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_valid (instr_valid),
    .o_rdata (instruction)
  );

  assign req_ready   = (r_state == IDLE);
  assign err_invalid = r_err;
  assign busy        = (r_state == BURST) || !w_empty;

endmodule

// File: tb/tb_mmu_encoder.sv
// Directed self-checking bench for mmu_encoder (DEPTH = 4).
module tb_mmu_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_ld = 1'b0;
  logic        req_st = 1'b0;
  logic [3:0]  req_reg_addr = 4'd0;
  logic [3:0]  req_mem_addr = 4'd0;
  logic [3:0]  req_sl_select = 4'd0;
  logic [3:0]  req_len = 4'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [29:0] instruction;
  logic        err_invalid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mmu_encoder #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ld       (req_ld),
    .req_st       (req_st),
    .req_reg_addr (req_reg_addr),
    .req_mem_addr (req_mem_addr),
    .req_sl_select(req_sl_select),
    .req_len      (req_len),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .err_invalid  (err_invalid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [3:0] rg,
                               input logic [3:0] mm, input logic [3:0] sl, input logic [3:0] ln);
    req_ld        = ld;
    req_st        = st;
    req_reg_addr  = rg;
    req_mem_addr  = mm;
    req_sl_select = sl;
    req_len       = ln;
    req_valid     = 1'b1;
  endtask

  function automatic logic [29:0] packWord(input logic st, input logic ld, input logic [3:0] rg,
                                           input logic [3:0] mm, input logic [3:0] sl);
    logic [13:0] hi;
    logic [13:0] lo;
    logic [1:0]  par;
    hi = {st, ld, rg, mm, sl};
    lo = {sl, mm, rg, ld, st};
`ifdef MMU_ENCODER_PARITY_EN
    par = {^hi, ^lo};
`else
    par = 2'b00;
`endif
    return {hi, par, lo};
  endfunction

  logic [1:0] expPar;
  int collected;
  int firstReady;

  initial begin
`ifdef MMU_ENCODER_PARITY_EN
    expPar = 2'b11;
`else
    expPar = 2'b00;
`endif
    #3;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instruction", 32'(instruction), 32'd0);
    checkOutput("rst_err_invalid", 32'(err_invalid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Scenario 1 / 6: single load, latency and packing
    $display("[TB] single load");
    instr_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd3, 4'd5, 4'd9, 4'd0);
    step();
    req_valid = 1'b0;
    checkOutput("s1_ready_low", 32'(req_ready), 32'd0);
    checkOutput("s1_valid_n0", 32'(instr_valid), 32'd0);
    step();
    checkOutput("s1_valid_n1", 32'(instr_valid), 32'd0);
    checkOutput("s1_busy", 32'(busy), 32'd1);
    checkOutput("s1_ready_back", 32'(req_ready), 32'd1);
    step();
    checkOutput("s1_valid_n2", 32'(instr_valid), 32'd1);
    checkOutput("s1_hi", 32'(instruction[29:16]), 32'(14'b01_0011_0101_1001));
    checkOutput("s1_lo", 32'(instruction[13:0]), 32'(14'b1001_0101_0011_10));
    checkOutput("s6_parity", 32'(instruction[15:14]), 32'(expPar));
    step();
    checkOutput("s1_valid_drained", 32'(instr_valid), 32'd0);
    checkOutput("s1_idle", 32'(busy), 32'd0);

    // Scenario 2: burst with address wrap
    $display("[TB] burst wrap");
    applyStimulus(1'b0, 1'b1, 4'd7, 4'd14, 4'd2, 4'd3);
    step();
    req_valid = 1'b0;
    checkOutput("s2_ready_n0", 32'(req_ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      checkOutput($sformatf("s2_ready_n%0d", k), 32'(req_ready), (k >= 4) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        checkOutput($sformatf("s2_valid_n%0d", k), 32'(instr_valid), 32'd1);
        checkOutput($sformatf("s2_word_n%0d", k), 32'(instruction),
                    32'(packWord(1'b1, 1'b0, 4'd7, 4'(14 + k - 2), 4'd2)));
      end
    end
    step();
    checkOutput("s2_drained", 32'(instr_valid), 32'd0);

    // Scenario 3: backpressure with a full FIFO
    $display("[TB] backpressure");
    instr_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd1, 4'd3, 4'd4, 4'd7);
    step();
    req_valid = 1'b0;
    repeat (6) step();
    checkOutput("s3_stalled_ready", 32'(req_ready), 32'd0);
    checkOutput("s3_stalled_valid", 32'(instr_valid), 32'd1);
    checkOutput("s3_stalled_head", 32'(instruction), 32'(packWord(1'b0, 1'b1, 4'd1, 4'd3, 4'd4)));
    instr_ready = 1'b1;
    collected = 0;
    firstReady = -1;
    for (int c = 0; c < 14; c++) begin
      if (instr_valid) begin
        if (collected < 8)
          checkOutput($sformatf("s3_word%0d", collected), 32'(instruction),
                      32'(packWord(1'b0, 1'b1, 4'd1, 4'(3 + collected), 4'd4)));
        collected++;
      end
      if (req_ready && firstReady < 0) firstReady = c;
      step();
    end
    checkOutput("s3_word_count", 32'(collected), 32'd8);
    checkOutput("s3_ready_cycle", 32'(firstReady), 32'd5);
    checkOutput("s3_idle", 32'(busy), 32'd0);

    // Scenario 4: invalid opcodes
    $display("[TB] invalid opcodes");
    applyStimulus(1'b1, 1'b1, 4'd2, 4'd2, 4'd2, 4'd0);
    step();
    req_valid = 1'b0;
    checkOutput("s4_err_both", 32'(err_invalid), 32'd1);
    checkOutput("s4_ready_both", 32'(req_ready), 32'd1);
    step();
    checkOutput("s4_err_clear1", 32'(err_invalid), 32'd0);
    checkOutput("s4_valid1", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd2, 4'd2, 4'd2, 4'd0);
    step();
    req_valid = 1'b0;
    checkOutput("s4_err_none", 32'(err_invalid), 32'd1);
    step();
    checkOutput("s4_err_clear2", 32'(err_invalid), 32'd0);
    checkOutput("s4_valid2", 32'(instr_valid), 32'd0);
    checkOutput("s4_busy", 32'(busy), 32'd0);

    // Scenario 5: asynchronous reset mid-burst
    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 1'b0, 4'd6, 4'd0, 4'd1, 4'd5);
    step();
    req_valid = 1'b0;
    step();
    step();
    checkOutput("s5_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_ready", 32'(req_ready), 32'd1);
    checkOutput("s5_rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("s5_rst_instr", 32'(instruction), 32'd0);
    checkOutput("s5_rst_err", 32'(err_invalid), 32'd0);
    checkOutput("s5_rst_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    step();
    checkOutput("s5_post_valid", 32'(instr_valid), 32'd0);
    checkOutput("s5_post_busy", 32'(busy), 32'd0);
    checkOutput("s5_post_ready", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
